sys_bridge_n: RTL

//  Parametrised CPU-side system bridge between the pipeline's data port and the data memory plus NUM_DEV

---
 rtl/bridge_pkg.sv | 27 ++
 rtl/irq_sync_latch.sv | 39 +++
 rtl/sys_bridge_n.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bridge_pkg : target ids, CSR offsets and error-counter width for the bridge |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package bridge_pkg;

  localparam int unsigned TGT_W = 4;
  typedef logic [TGT_W-1:0] tgt_id_t;

  localparam tgt_id_t TGT_MEM  = 4'd0;
  localparam tgt_id_t TGT_CSR  = 4'd1;
  localparam tgt_id_t TGT_DEV0 = 4'd2;
  localparam tgt_id_t TGT_NONE = 4'd15;

  localparam logic [31:0] CSR_OFF_PEND = 32'h0000_0000;
  localparam logic [31:0] CSR_OFF_ERR  = 32'h0000_0004;

  localparam int unsigned ERR_CNT_W = 8;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  function automatic tgt_id_t dev_tgt(input int idx);
    return TGT_DEV0 + tgt_id_t'(idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_sync_latch : 2FF synchroniser, rising-edge detect, W1C pending bit      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module irq_sync_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_async,
  input  logic clr,
  output logic pend
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync_prev;
  logic r_pend;
  logic w_rise;

  assign w_rise = r_sync2 & ~r_sync_prev;
  assign pend   = r_pend;

  // A new edge takes precedence over a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_sync1     <= irq_async;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_pend      <= w_rise | (r_pend & ~clr);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sys_bridge_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_bridge_n : CPU data-port bridge to data memory, CSRs and peripherals    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sys_bridge_n
  import bridge_pkg::*;
#(
  parameter int                     NUM_DEV  = 2,
  parameter logic [31:0]            MEM_BASE = 32'h0000_0000,
  parameter logic [31:0]            MEM_SIZE = 32'h0000_3000,
  parameter logic [NUM_DEV*32-1:0]  DEV_BASE = {32'h0000_7F10, 32'h0000_7F00},
  parameter logic [NUM_DEV*32-1:0]  DEV_MASK = {NUM_DEV{32'hFFFF_FFF0}},
  parameter logic [31:0]            CSR_BASE = 32'h0000_7F80
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_byteen,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_rvalid,
  output logic                    cpu_err,
  output logic [31:0]             m_data_addr,
  output logic [31:0]             m_data_wdata,
  output logic [3:0]              m_data_byteen,
  input  logic [31:0]             m_data_rdata,
  output logic [31:0]             dev_addr,
  output logic [31:0]             dev_wdata,
  output logic [NUM_DEV-1:0]      dev_we,
  input  logic [NUM_DEV*32-1:0]   dev_rdata,
  input  logic [NUM_DEV-1:0]      dev_irq,
  output logic [NUM_DEV-1:0]      hw_int
);

  logic [31:0]        w_mem_off;
  logic               w_mem_hit;
  logic               w_csr_hit;
  logic               w_csr_err_addr;
  logic               w_wr;
  logic               w_full;
  logic               w_illegal;
  logic               w_full_wr;
  tgt_id_t            w_tgt;
  logic [NUM_DEV-1:0] w_dev_hit;
  logic [31:0]        w_dev_rd;
  logic [31:0]        w_csr_rd;
  logic [31:0]        w_cap;
  logic [NUM_DEV-1:0] w_pend_clr;

  logic               r_rvalid;
  logic               r_err;
  err_cnt_t           r_err_cnt;
  tgt_id_t            r_sel;
  logic [31:0]        r_rdata;

  // Offset compare wraps, so any MEM_BASE works without a lower-bound test
  assign w_mem_off      = cpu_addr - MEM_BASE;
  assign w_mem_hit      = w_mem_off < MEM_SIZE;
  assign w_csr_err_addr = cpu_addr == (CSR_BASE + CSR_OFF_ERR);
  assign w_csr_hit      = (cpu_addr == (CSR_BASE + CSR_OFF_PEND)) || w_csr_err_addr;

  always_comb begin
    w_tgt     = TGT_NONE;
    w_dev_hit = '0;
    w_dev_rd  = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if ((cpu_addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]) begin
        w_tgt        = dev_tgt(i);
        w_dev_hit    = '0;
        w_dev_hit[i] = 1'b1;
        w_dev_rd     = dev_rdata[32*i +: 32];
      end
    end
    if (w_csr_hit || w_mem_hit) begin
      w_tgt     = w_mem_hit ? TGT_MEM : TGT_CSR;
      w_dev_hit = '0;
      w_dev_rd  = '0;
    end
  end

  assign w_wr      = |cpu_byteen;
  assign w_full    = &cpu_byteen;
  assign w_full_wr = cpu_req & w_wr & w_full;

  assign w_illegal = cpu_req & ((w_tgt == TGT_NONE)
                              | (w_wr & (w_tgt != TGT_MEM) & ~w_full)
                              | (w_wr & (w_tgt == TGT_CSR) & w_csr_err_addr));

  assign m_data_addr   = cpu_addr;
  assign m_data_wdata  = cpu_wdata;
  assign m_data_byteen = (cpu_req && (w_tgt == TGT_MEM)) ? cpu_byteen : 4'b0000;
  assign dev_addr      = cpu_addr;
  assign dev_wdata     = cpu_wdata;
  assign dev_we        = w_full_wr ? w_dev_hit : '0;

  assign w_pend_clr = (w_full_wr && (w_tgt == TGT_CSR) && !w_csr_err_addr)
                    ? cpu_wdata[NUM_DEV-1:0] : '0;

  assign w_csr_rd = w_csr_err_addr ? {{(32-ERR_CNT_W){1'b0}}, r_err_cnt}
                                   : {{(32-NUM_DEV){1'b0}}, hw_int};
  assign w_cap    = (w_tgt == TGT_CSR) ? w_csr_rd : w_dev_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_sel     <= TGT_NONE;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= cpu_req & ~w_wr;
      r_err    <= w_illegal;
      if (w_illegal && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + err_cnt_t'(1);
      end
      if (cpu_req && !w_wr) begin
        r_sel   <= w_tgt;
        r_rdata <= w_cap;
      end
    end
  end

  // DM answers a cycle after the address, so its data is muxed in live
  assign cpu_rvalid = r_rvalid;
  assign cpu_err    = r_err;
  assign cpu_rdata  = !r_rvalid ? '0 : ((r_sel == TGT_MEM) ? m_data_rdata : r_rdata);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEV; gi++) begin : g_irq
      irq_sync_latch u_irq (
        .clk       (clk),
        .reset     (reset),
        .irq_async (dev_irq[gi]),
        .clr       (w_pend_clr[gi]),
        .pend      (hw_int[gi])
      );
    end
  endgenerate

endmodule
`default_nettype wire
